// File: rtl/chunk_sub_pkg.sv
// Shared chunk geometry for the pipelined chunk subtractor: chunk width, stage count and
// the lane mask that trims a partial top chunk.
package chunk_sub_pkg;

    localparam int unsigned CHUNK_W = 8;

    typedef logic [CHUNK_W-1:0] chunk_t;

    function automatic int unsigned stages_f(input int unsigned width);
        return (width + CHUNK_W - 1) / CHUNK_W;
    endfunction

    // Only the top chunk can be partial; every other chunk uses all lanes.
    function automatic chunk_t lane_mask_f(input int unsigned width, input int unsigned stage);
        int unsigned rem;
        rem = width % CHUNK_W;
        if (rem != 0 && stage == stages_f(width) - 1) begin
            return chunk_t'((1 << rem) - 1);
        end
        return '1;
    endfunction

endpackage

// File: rtl/chunk_borrow_slice.sv
// Combinational 8-lane subtract chunk in carry-chain form: S = x ^ ~y, DI = x, CI = ~borrow.
// Masked-off lanes pass the carry straight through, so borrow_o reflects the top used lane.
module chunk_borrow_slice
    import chunk_sub_pkg::*;
(
    input  chunk_t x_i,
    input  chunk_t y_i,
    input  logic   borrow_i,
    input  chunk_t mask_i,
    output chunk_t d_o,
    output logic   borrow_o
);

    chunk_t prop;
    logic   carry;

    always_comb begin
        prop  = x_i ^ ~y_i;
        carry = ~borrow_i;
        d_o   = '0;
        for (int i = 0; i < int'(CHUNK_W); i++) begin
            if (mask_i[i]) begin
                d_o[i] = prop[i] ^ carry;
                carry  = prop[i] ? carry : x_i[i];
            end
        end
        borrow_o = ~carry;
    end

endmodule

// File: rtl/pipelined_chunk_subtractor.sv
// Wide unsigned subtractor d = x - y - borrow_in, resolving one 8-bit chunk per lockstep
// pipeline stage with the borrow registered between stages.
module pipelined_chunk_subtractor
    import chunk_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned STAGES = stages_f(WIDTH);
    localparam int unsigned PAD_W  = STAGES * CHUNK_W;
    // Operand skew and partial results are triangular; both are packed flat, stage by stage.
    localparam int unsigned SKEW_W = (STAGES > 1) ? CHUNK_W * STAGES * (STAGES - 1) / 2 : 1;
    localparam int unsigned PART_W = CHUNK_W * STAGES * (STAGES + 1) / 2;

    logic              adv;
    logic              accept;
    logic [PAD_W-1:0]  x_pad;
    logic [PAD_W-1:0]  y_pad;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] borrow_q, borrow_d;
    logic [SKEW_W-1:0] x_skew_q, x_skew_d;
    logic [SKEW_W-1:0] y_skew_q, y_skew_d;
    logic [PART_W-1:0] part_q, part_d;

    chunk_t            chunk_x [STAGES];
    chunk_t            chunk_y [STAGES];
    chunk_t            chunk_d [STAGES];
    logic [STAGES-1:0] chunk_bin;
    logic [STAGES-1:0] chunk_bout;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign x_pad    = PAD_W'(x);
    assign y_pad    = PAD_W'(y);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned RemW    = PAD_W - CHUNK_W * (k + 1);
        localparam int unsigned SkOff   = k * PAD_W - CHUNK_W * k * (k + 1) / 2;
        localparam int unsigned PartW   = CHUNK_W * (k + 1);
        localparam int unsigned PartOff = CHUNK_W * k * (k + 1) / 2;
        localparam chunk_t      LaneMask = lane_mask_f(WIDTH, k);

        if (k == 0) begin : g_first
            assign chunk_x[0]   = x_pad[CHUNK_W-1:0];
            assign chunk_y[0]   = y_pad[CHUNK_W-1:0];
            assign chunk_bin[0] = borrow_in;
            assign valid_d[0]   = in_valid;
            // Data registers hold on idle cycles; only the valid bit clears.
            assign borrow_d[0]  = accept ? chunk_bout[0] : borrow_q[0];
            assign part_d[0 +: CHUNK_W] = accept ? chunk_d[0] : part_q[0 +: CHUNK_W];
            if (STAGES > 1) begin : g_skew
                assign x_skew_d[0 +: RemW] = accept ? x_pad[PAD_W-1:CHUNK_W] : x_skew_q[0 +: RemW];
                assign y_skew_d[0 +: RemW] = accept ? y_pad[PAD_W-1:CHUNK_W] : y_skew_q[0 +: RemW];
            end
        end else begin : g_rest
            localparam int unsigned PrevSkOff   = (k - 1) * PAD_W - CHUNK_W * (k - 1) * k / 2;
            localparam int unsigned PrevPartW   = CHUNK_W * k;
            localparam int unsigned PrevPartOff = CHUNK_W * (k - 1) * k / 2;

            assign chunk_x[k]   = x_skew_q[PrevSkOff +: CHUNK_W];
            assign chunk_y[k]   = y_skew_q[PrevSkOff +: CHUNK_W];
            assign chunk_bin[k] = borrow_q[k-1];
            assign valid_d[k]   = valid_q[k-1];
            assign borrow_d[k]  = chunk_bout[k];
            assign part_d[PartOff +: PartW] = {chunk_d[k], part_q[PrevPartOff +: PrevPartW]};
            if (k < STAGES - 1) begin : g_skew
                assign x_skew_d[SkOff +: RemW] = x_skew_q[PrevSkOff + CHUNK_W +: RemW];
                assign y_skew_d[SkOff +: RemW] = y_skew_q[PrevSkOff + CHUNK_W +: RemW];
            end
        end

        chunk_borrow_slice u_slice (
            .x_i      (chunk_x[k]),
            .y_i      (chunk_y[k]),
            .borrow_i (chunk_bin[k]),
            .mask_i   (LaneMask),
            .d_o      (chunk_d[k]),
            .borrow_o (chunk_bout[k])
        );
    end

    if (STAGES == 1) begin : g_no_skew
        assign x_skew_d = '0;
        assign y_skew_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= '0;
            borrow_q <= '0;
            x_skew_q <= '0;
            y_skew_q <= '0;
            part_q   <= '0;
        end else if (adv) begin
            valid_q  <= valid_d;
            borrow_q <= borrow_d;
            x_skew_q <= x_skew_d;
            y_skew_q <= y_skew_d;
            part_q   <= part_d;
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign borrow_out = borrow_q[STAGES-1];
    assign diff       = part_q[PART_W-PAD_W +: WIDTH];

endmodule

// File: tb/tb_pipelined_chunk_subtractor.sv
// Scoreboard bench: accepted beats push an arithmetic reference result; monitors pop and
// compare on every output transfer. Covers WIDTH=32 and a partial-top-chunk WIDTH=12 instance.
module tb_pipelined_chunk_subtractor;

    localparam int unsigned WA = 32;
    localparam int unsigned WB = 12;
    localparam int unsigned NA = 10000;
    localparam int unsigned NB = 2000;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_borrow_in, a_out_valid, a_out_ready, a_borrow_out;
    logic [WA-1:0] a_x, a_y, a_diff;
    logic          b_in_valid, b_in_ready, b_borrow_in, b_out_valid, b_out_ready, b_borrow_out;
    logic [WB-1:0] b_x, b_y, b_diff;

    pipelined_chunk_subtractor #(.WIDTH(WA)) dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .x          (a_x),
        .y          (a_y),
        .borrow_in  (a_borrow_in),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .diff       (a_diff),
        .borrow_out (a_borrow_out)
    );

    pipelined_chunk_subtractor #(.WIDTH(WB)) dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .x          (b_x),
        .y          (b_y),
        .borrow_in  (b_borrow_in),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .diff       (b_diff),
        .borrow_out (b_borrow_out)
    );

    int errors = 0;
    int checks = 0;
    int a_seen = 0;
    int b_seen = 0;
    logic [64:0] a_exp_q[$];
    logic [64:0] b_exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain wide arithmetic; result is {borrow, diff mod 2^width}.
    function automatic logic [64:0] model(input int unsigned width, input logic [63:0] xv,
                                          input logic [63:0] yv, input logic bin);
        logic [64:0] lhs;
        logic [64:0] rhs;
        logic [63:0] mask;
        logic [64:0] full;
        lhs  = {1'b0, xv};
        rhs  = {1'b0, yv} + 65'(bin);
        mask = (64'd1 << width) - 64'd1;
        full = lhs - rhs;
        return {rhs > lhs, full[63:0] & mask};
    endfunction

    // Expected results are queued at acceptance; reset flushes everything in flight.
    always @(negedge clk) begin
        if (!rstn) begin
            a_exp_q.delete();
            b_exp_q.delete();
        end else begin
            if (a_in_valid && a_in_ready) a_exp_q.push_back(model(WA, 64'(a_x), 64'(a_y), a_borrow_in));
            if (b_in_valid && b_in_ready) b_exp_q.push_back(model(WB, 64'(b_x), 64'(b_y), b_borrow_in));
        end
    end

    bit          a_stalled = 0;
    logic [WA:0] a_hold;
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rstn) begin
            a_stalled = 0;
        end else begin
            if (a_stalled) begin
                check("a_stall_valid", 64'(a_out_valid), 64'd1);
                check("a_stall_hold", 64'({a_borrow_out, a_diff}), 64'(a_hold));
            end
            a_stalled = a_out_valid && !a_out_ready;
            if (a_stalled) begin
                a_hold = {a_borrow_out, a_diff};
                check("a_stall_in_ready", 64'(a_in_ready), 64'd0);
            end
            if (a_out_valid && a_out_ready) begin
                if (a_exp_q.size() == 0) begin
                    check("a_unexpected_beat", 64'(a_out_valid), 64'd0);
                end else begin
                    e = a_exp_q.pop_front();
                    check("a_diff", 64'(a_diff), e[63:0]);
                    check("a_borrow", 64'(a_borrow_out), 64'(e[64]));
                    a_seen++;
                end
            end
        end
    end

    bit          b_stalled = 0;
    logic [WB:0] b_hold;
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rstn) begin
            b_stalled = 0;
        end else begin
            if (b_stalled) begin
                check("b_stall_valid", 64'(b_out_valid), 64'd1);
                check("b_stall_hold", 64'({b_borrow_out, b_diff}), 64'(b_hold));
            end
            b_stalled = b_out_valid && !b_out_ready;
            if (b_stalled) begin
                b_hold = {b_borrow_out, b_diff};
                check("b_stall_in_ready", 64'(b_in_ready), 64'd0);
            end
            if (b_out_valid && b_out_ready) begin
                if (b_exp_q.size() == 0) begin
                    check("b_unexpected_beat", 64'(b_out_valid), 64'd0);
                end else begin
                    e = b_exp_q.pop_front();
                    check("b_diff", 64'(b_diff), e[63:0]);
                    check("b_borrow", 64'(b_borrow_out), 64'(e[64]));
                    b_seen++;
                end
            end
        end
    end

    task automatic check_idle(input string name);
        check({name, "_a_in_ready"}, 64'(a_in_ready), 64'd1);
        check({name, "_a_out_valid"}, 64'(a_out_valid), 64'd0);
        check({name, "_a_diff"}, 64'(a_diff), 64'd0);
        check({name, "_a_borrow"}, 64'(a_borrow_out), 64'd0);
        check({name, "_b_in_ready"}, 64'(b_in_ready), 64'd1);
        check({name, "_b_out_valid"}, 64'(b_out_valid), 64'd0);
        check({name, "_b_diff"}, 64'(b_diff), 64'd0);
        check({name, "_b_borrow"}, 64'(b_borrow_out), 64'd0);
    endtask

    // One beat into an empty pipe; measures cycles from presentation to out_valid.
    task automatic directed(input string name, input bit use_b, input logic [31:0] xv,
                            input logic [31:0] yv, input logic bin, input logic [31:0] ed,
                            input logic eb, input int lat);
        int n;
        @(posedge clk); #1;
        if (use_b) begin
            b_out_ready = 1; b_x = WB'(xv); b_y = WB'(yv); b_borrow_in = bin; b_in_valid = 1;
        end else begin
            a_out_ready = 1; a_x = xv; a_y = yv; a_borrow_in = bin; a_in_valid = 1;
        end
        @(posedge clk); #1;
        a_in_valid = 0;
        b_in_valid = 0;
        n = 1;
        while (!(use_b ? b_out_valid : a_out_valid) && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_diff"}, use_b ? 64'(b_diff) : 64'(a_diff), 64'(ed));
        check({name, "_borrow"}, use_b ? 64'(b_borrow_out) : 64'(a_borrow_out), 64'(eb));
    endtask

    task automatic drain(input string name);
        int n;
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        n = 0;
        while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_a_left"}, 64'(a_exp_q.size()), 64'd0);
        check({name, "_b_left"}, 64'(b_exp_q.size()), 64'd0);
    endtask

    initial begin
        int sent;
        int seen0;
        int a_sent;
        int b_sent;
        int r;
        rstn = 0;
        a_in_valid = 0; a_x = '0; a_y = '0; a_borrow_in = 0; a_out_ready = 1;
        b_in_valid = 0; b_x = '0; b_y = '0; b_borrow_in = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("in_reset");
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
        check_idle("after_reset");

        directed("basic", 0, 32'h0000_0100, 32'h0000_0001, 0, 32'h0000_00FF, 0, 4);
        directed("ripple", 0, 32'h0, 32'h1, 0, 32'hFFFF_FFFF, 1, 4);
        directed("bin_only", 0, 32'h8000_0000, 32'h8000_0000, 1, 32'hFFFF_FFFF, 1, 4);
        directed("bin_zero", 0, 32'h8000_0000, 32'h8000_0000, 0, 32'h0, 0, 4);
        directed("w12_wrap", 1, 32'h000, 32'h001, 0, 32'hFFF, 1, 2);
        directed("w12_plain", 1, 32'hFFF, 32'h001, 0, 32'hFFE, 0, 2);
        drain("directed");

        // Six back-to-back beats with a three-cycle output stall in the middle.
        sent = 0;
        seen0 = a_seen;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk); #1;
            a_out_ready = !(cyc >= 4 && cyc < 7);
            a_in_valid  = (sent < 6);
            a_x = 32'd1000 + 32'(sent) * 32'd3;
            a_y = 32'(sent);
            a_borrow_in = sent[0];
            @(negedge clk);
            if (a_in_valid && a_in_ready) sent++;
        end
        drain("backpressure");
        check("bp_beats_out", 64'(a_seen - seen0), 64'd6);

        // Reset with three beats in flight: none may come out afterwards.
        seen0 = a_seen;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_out_ready = 1; a_in_valid = 1;
            a_x = 32'h1234_0000 + 32'(i); a_y = 32'd7; a_borrow_in = 0;
        end
        @(posedge clk); #1;
        a_in_valid = 0;
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        #1;
        check_idle("mid_reset");
        repeat (8) @(posedge clk);
        #1;
        check("reset_no_stale", 64'(a_seen - seen0), 64'd0);

        // Random traffic on both instances with random valid and ready.
        a_sent = 0;
        b_sent = 0;
        for (int cyc = 0; cyc < 60000 && (a_sent < int'(NA) || b_sent < int'(NB)); cyc++) begin
            @(posedge clk); #1;
            r = int'($urandom_range(7));
            a_in_valid  = (a_sent < int'(NA)) && ($urandom_range(3) != 0);
            a_y         = $urandom;
            a_x         = (r == 0) ? a_y : (r == 1) ? '0 : (r == 2) ? '1 : $urandom;
            a_borrow_in = 1'($urandom_range(1));
            a_out_ready = ($urandom_range(3) != 0);
            r = int'($urandom_range(7));
            b_in_valid  = (b_sent < int'(NB)) && ($urandom_range(1) != 0);
            b_y         = WB'($urandom);
            b_x         = (r == 0) ? b_y : (r == 1) ? '0 : (r == 2) ? '1 : WB'($urandom);
            b_borrow_in = 1'($urandom_range(1));
            b_out_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (a_in_valid && a_in_ready) a_sent++;
            if (b_in_valid && b_in_ready) b_sent++;
        end
        check("rand_a_sent", 64'(a_sent), 64'(NA));
        check("rand_b_sent", 64'(b_sent), 64'(NB));
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
